// File: rtl/tcp_open_arbiter_pkg.sv
// Shared request/response layouts, FSM state encoding and defaults for tcp_open_arbiter.
// Bit widths follow the connection-table request/response records.
package tcp_open_arbiter_pkg;

  localparam int N_REGIONS_DEF        = 4;
  localparam int TCP_OPEN_TIMEOUT_DEF = 2**20;

  typedef struct packed {
    logic [31:0] ip_address;
    logic [15:0] ip_port;
    logic [5:0]  pid;
    logic [3:0]  dest;
    logic [13:0] route_id;
    logic        close;
    logic [3:0]  vfid;
  } tcp_open_req_r_t;

  typedef struct packed {
    logic [3:0] vfid;
    logic [5:0] pid;
    logic [9:0] sid;
    logic       success;
  } tcp_open_rsp_r_t;

  localparam int REQ_W = $bits(tcp_open_req_r_t);
  localparam int RSP_W = $bits(tcp_open_rsp_r_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_WAIT_RSP,
    ST_RSP
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_open_arbiter_rr_arbiter_n.sv
// Combinational round-robin pick: first asserted request at or after ptr, modulo N.
// Zero latency; the caller owns the pointer and any backpressure.
module rr_arbiter_n #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/tcp_open_arbiter.sv
// Serialises per-vFPGA TCP open/close requests (one open in flight), routes responses back by vfid.
// Request accept->fwd valid 1 cycle, rsp accept->per-port valid 1 cycle; optional TCP_OPEN_TIMEOUT_EN.
module tcp_open_arbiter
  import tcp_open_arbiter_pkg::*;
#(
  parameter int N_REGIONS = N_REGIONS_DEF
`ifdef TCP_OPEN_TIMEOUT_EN
  , parameter int OPEN_TIMEOUT = TCP_OPEN_TIMEOUT_DEF
`endif
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_REGIONS-1:0]       s_open_req_vld,
  output logic [N_REGIONS-1:0]       s_open_req_rdy,
  input  logic [N_REGIONS*REQ_W-1:0] s_open_req_dat,
  output logic                       m_open_req_vld,
  input  logic                       m_open_req_rdy,
  output logic [REQ_W-1:0]           m_open_req_dat,
  input  logic                       s_open_rsp_vld,
  output logic                       s_open_rsp_rdy,
  input  logic [RSP_W-1:0]           s_open_rsp_dat,
  output logic [N_REGIONS-1:0]       m_open_rsp_vld,
  input  logic [N_REGIONS-1:0]       m_open_rsp_rdy,
  output logic [RSP_W-1:0]           m_open_rsp_dat,
  output logic [15:0]                drop_cnt
);

  localparam int IDX_W = idx_width(N_REGIONS);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  tcp_open_req_r_t        req_q, req_d;
  logic                   m_req_vld_q, m_req_vld_d;
  tcp_open_rsp_r_t        rsp_q, rsp_d;
  logic [N_REGIONS-1:0]   m_rsp_vld_q, m_rsp_vld_d;
  logic [15:0]            drop_q, drop_d;
`ifdef TCP_OPEN_TIMEOUT_EN
  logic [31:0]            tmo_q, tmo_d;
`endif

  logic [N_REGIONS-1:0]   gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any;
  tcp_open_req_r_t        sel_req;
  tcp_open_rsp_r_t        rsp_in;
  logic                   rsp_fire;
  logic                   rsp_match;
  logic                   drop_inc;

  rr_arbiter_n #(.N(N_REGIONS), .IDX_W(IDX_W)) u_rr (
    .req (s_open_req_vld),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Readies are held low while reset is asserted so nothing handshakes during reset.
  assign s_open_req_rdy = (!areset && state_q == ST_IDLE) ? gnt : '0;
  assign s_open_rsp_rdy = !areset && (state_q != ST_RSP);
  assign m_open_req_vld = m_req_vld_q;
  assign m_open_req_dat = req_q;
  assign m_open_rsp_vld = m_rsp_vld_q;
  assign m_open_rsp_dat = rsp_q;
  assign drop_cnt       = drop_q;

  assign sel_req   = s_open_req_dat[int'(gnt_idx)*REQ_W +: REQ_W];
  assign rsp_in    = s_open_rsp_dat;
  assign rsp_fire  = s_open_rsp_vld && s_open_rsp_rdy;
  assign rsp_match = rsp_fire && ({rsp_in.vfid, rsp_in.pid} == {req_q.vfid, req_q.pid});

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    req_d       = req_q;
    m_req_vld_d = m_req_vld_q;
    rsp_d       = rsp_q;
    m_rsp_vld_d = m_rsp_vld_q;
    drop_inc    = 1'b0;
`ifdef TCP_OPEN_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        drop_inc = rsp_fire;
        if (gnt_any) begin
          req_d       = sel_req;
          req_d.vfid  = 4'(gnt_idx);
          rr_ptr_d    = (int'(gnt_idx) == N_REGIONS - 1) ? '0 : gnt_idx + IDX_W'(1);
          m_req_vld_d = 1'b1;
          state_d     = ST_FWD;
        end
      end
      ST_FWD: begin
        drop_inc = rsp_fire;
        if (m_open_req_rdy) begin
          m_req_vld_d = 1'b0;
          state_d     = req_q.close ? ST_IDLE : ST_WAIT_RSP;
`ifdef TCP_OPEN_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_match) begin
          rsp_d                               = rsp_in;
          m_rsp_vld_d                         = '0;
          m_rsp_vld_d[req_q.vfid[IDX_W-1:0]]  = 1'b1;
          state_d                             = ST_RSP;
        end else begin
          drop_inc = rsp_fire;
`ifdef TCP_OPEN_TIMEOUT_EN
          if (tmo_q == 32'(OPEN_TIMEOUT - 1)) begin
            rsp_d                              = '{vfid: req_q.vfid, pid: req_q.pid, sid: '0, success: 1'b0};
            m_rsp_vld_d                        = '0;
            m_rsp_vld_d[req_q.vfid[IDX_W-1:0]] = 1'b1;
            state_d                            = ST_RSP;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
`endif
        end
      end
      ST_RSP: begin
        if (|(m_rsp_vld_q & m_open_rsp_rdy)) begin
          m_rsp_vld_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      req_q       <= '0;
      m_req_vld_q <= 1'b0;
      rsp_q       <= '0;
      m_rsp_vld_q <= '0;
      drop_q      <= '0;
`ifdef TCP_OPEN_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_q       <= req_d;
      m_req_vld_q <= m_req_vld_d;
      rsp_q       <= rsp_d;
      m_rsp_vld_q <= m_rsp_vld_d;
      drop_q      <= drop_d;
`ifdef TCP_OPEN_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_tcp_open_arbiter.sv
// Scoreboard bench for tcp_open_arbiter: directed stimulus pushes expected traffic, a monitor pops and compares.
module tb_tcp_open_arbiter;
  import tcp_open_arbiter_pkg::*;

  localparam int N = 4;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic [N-1:0]       s_open_req_vld = '0;
  logic [N-1:0]       s_open_req_rdy;
  logic [N*REQ_W-1:0] s_open_req_dat = '0;
  logic               m_open_req_vld;
  logic               m_open_req_rdy = 1'b1;
  logic [REQ_W-1:0]   m_open_req_dat;
  logic               s_open_rsp_vld = 1'b0;
  logic               s_open_rsp_rdy;
  logic [RSP_W-1:0]   s_open_rsp_dat = '0;
  logic [N-1:0]       m_open_rsp_vld;
  logic [N-1:0]       m_open_rsp_rdy = '1;
  logic [RSP_W-1:0]   m_open_rsp_dat;
  logic [15:0]        drop_cnt;

  tcp_open_arbiter #(
    .N_REGIONS(N)
`ifdef TCP_OPEN_TIMEOUT_EN
    , .OPEN_TIMEOUT(100)
`endif
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_open_req_vld (s_open_req_vld),
    .s_open_req_rdy (s_open_req_rdy),
    .s_open_req_dat (s_open_req_dat),
    .m_open_req_vld (m_open_req_vld),
    .m_open_req_rdy (m_open_req_rdy),
    .m_open_req_dat (m_open_req_dat),
    .s_open_rsp_vld (s_open_rsp_vld),
    .s_open_rsp_rdy (s_open_rsp_rdy),
    .s_open_rsp_dat (s_open_rsp_dat),
    .m_open_rsp_vld (m_open_rsp_vld),
    .m_open_rsp_rdy (m_open_rsp_rdy),
    .m_open_rsp_dat (m_open_rsp_dat),
    .drop_cnt       (drop_cnt)
  );

  always #5 aclk = ~aclk;

  tcp_open_req_r_t exp_req_q[$];
  tcp_open_rsp_r_t exp_rsp_q[$];
  int              exp_port_q[$];
  int              tests = 0;
  int              fails = 0;
  logic [N-1:0]    last_acc;
  logic            last_mhs;
  tcp_open_req_r_t mon_req;
  tcp_open_rsp_r_t mon_rsp;
  int              mon_port;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no handshake within bound", name);
  endtask

  function automatic tcp_open_req_r_t mk_req(input logic [31:0] ip, input logic [15:0] port,
                                             input logic [5:0] pid, input logic cls, input logic [3:0] vfid);
    tcp_open_req_r_t r;
    r = '{ip_address: ip, ip_port: port, pid: pid, dest: 4'h3, route_id: 14'h1A5, close: cls, vfid: vfid};
    return r;
  endfunction

  function automatic tcp_open_rsp_r_t mk_rsp(input logic [3:0] vfid, input logic [5:0] pid,
                                             input logic [9:0] sid, input logic ok);
    tcp_open_rsp_r_t r;
    r = '{vfid: vfid, pid: pid, sid: sid, success: ok};
    return r;
  endfunction

  // Monitor: compares every handshake on the DUT outputs against the scoreboard queues.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_open_req_vld && m_open_req_rdy) begin
        if (exp_req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_unexpected: got %0h, nothing expected", m_open_req_dat);
        end else begin
          mon_req = exp_req_q.pop_front();
          chk("req_dat", 128'(m_open_req_dat), 128'(mon_req));
        end
      end
      if ($countones(m_open_rsp_vld) > 1) begin
        tests++; fails++;
        $display("FAIL rsp_onehot: got %b, at most one bit allowed", m_open_rsp_vld);
      end
      for (int p = 0; p < N; p++) begin
        if (m_open_rsp_vld[p] && m_open_rsp_rdy[p]) begin
          if (exp_rsp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL rsp_unexpected: got port %0d data %0h, nothing expected", p, m_open_rsp_dat);
          end else begin
            mon_rsp  = exp_rsp_q.pop_front();
            mon_port = exp_port_q.pop_front();
            chk("rsp_port", 128'(p), 128'(mon_port));
            chk("rsp_dat", 128'(m_open_rsp_dat), 128'(mon_rsp));
          end
        end
      end
    end
  end

  task automatic tick();
    logic [N-1:0] acc;
    logic         rhs;
    @(negedge aclk);
    acc      = s_open_req_vld & s_open_req_rdy;
    rhs      = s_open_rsp_vld && s_open_rsp_rdy;
    last_mhs = m_open_req_vld && m_open_req_rdy;
    @(posedge aclk);
    #1;
    s_open_req_vld = s_open_req_vld & ~acc;
    if (rhs) s_open_rsp_vld = 1'b0;
    last_acc = acc;
  endtask

  task automatic set_req(input int p, input tcp_open_req_r_t r);
    s_open_req_dat[p*REQ_W +: REQ_W] = r;
    s_open_req_vld[p] = 1'b1;
  endtask

  task automatic wait_acc(input int p);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc[p]) begin
        chk("req_latency", 128'(m_open_req_vld), 128'(1));
        return;
      end
    end
    bound_fail("wait_acc");
  endtask

  task automatic wait_fwd();
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_mhs) return;
    end
    bound_fail("wait_fwd");
  endtask

  task automatic send_rsp(input tcp_open_rsp_r_t r);
    s_open_rsp_dat = r;
    s_open_rsp_vld = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!s_open_rsp_vld) return;
    end
    s_open_rsp_vld = 1'b0;
    bound_fail("send_rsp");
  endtask

  int order[3] = '{1, 3, 0};

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_m_req_vld", 128'(m_open_req_vld), 128'(0));
    chk("rst_m_rsp_vld", 128'(m_open_rsp_vld), 128'(0));
    chk("rst_s_req_rdy", 128'(s_open_req_rdy), 128'(0));
    chk("rst_s_rsp_rdy", 128'(s_open_rsp_rdy), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    chk("rst_m_req_dat", 128'(m_open_req_dat), 128'(0));
    areset = 1'b0;
    tick();

    // Single open on port 2, response held by a stalled consumer for a few cycles
    exp_req_q.push_back(mk_req(32'h0A000001, 16'd5001, 6'd1, 1'b0, 4'd2));
    set_req(2, mk_req(32'h0A000001, 16'd5001, 6'd1, 1'b0, 4'hF));
    wait_acc(2);
    wait_fwd();
    m_open_rsp_rdy = '0;
    send_rsp(mk_rsp(4'd2, 6'd1, 10'd7, 1'b1));
    chk("rsp_latency", 128'(m_open_rsp_vld), 128'(4'b0100));
    repeat (3) tick();
    chk("rsp_hold_vld", 128'(m_open_rsp_vld), 128'(4'b0100));
    chk("rsp_hold_dat", 128'(m_open_rsp_dat), 128'(mk_rsp(4'd2, 6'd1, 10'd7, 1'b1)));
    exp_port_q.push_back(2);
    exp_rsp_q.push_back(mk_rsp(4'd2, 6'd1, 10'd7, 1'b1));
    m_open_rsp_rdy = '1;
    repeat (2) tick();

    // Close on port 1 with a forged vfid, then close on port 0; neither gets a response
    exp_req_q.push_back(mk_req(32'h0A000002, 16'd80, 6'd4, 1'b1, 4'd1));
    set_req(1, mk_req(32'h0A000002, 16'd80, 6'd4, 1'b1, 4'd5));
    wait_acc(1);
    wait_fwd();
    chk("close_idle_vld", 128'(m_open_req_vld), 128'(0));
    exp_req_q.push_back(mk_req(32'h0A000003, 16'd81, 6'd5, 1'b1, 4'd0));
    set_req(0, mk_req(32'h0A000003, 16'd81, 6'd5, 1'b1, 4'd0));
    wait_acc(0);
    wait_fwd();

    // Ports 0, 1, 3 at once with rr_ptr=1: grant order 1, 3, 0
    for (int k = 0; k < 3; k++)
      exp_req_q.push_back(mk_req(32'hC0A80000 + 32'(order[k]), 16'd6000, 6'(20 + order[k]), 1'b0, 4'(order[k])));
    set_req(0, mk_req(32'hC0A80000, 16'd6000, 6'd20, 1'b0, 4'd9));
    set_req(1, mk_req(32'hC0A80001, 16'd6000, 6'd21, 1'b0, 4'd9));
    set_req(3, mk_req(32'hC0A80003, 16'd6000, 6'd23, 1'b0, 4'd9));
    for (int k = 0; k < 3; k++) begin
      wait_fwd();
      exp_port_q.push_back(order[k]);
      exp_rsp_q.push_back(mk_rsp(4'(order[k]), 6'(20 + order[k]), 10'(order[k] + 10), 1'b1));
      send_rsp(mk_rsp(4'(order[k]), 6'(20 + order[k]), 10'(order[k] + 10), 1'b1));
    end
    repeat (2) tick();

    // Mismatched pid is dropped while waiting; the matching response then goes through
    exp_req_q.push_back(mk_req(32'h0A0000FE, 16'd443, 6'd9, 1'b0, 4'd3));
    set_req(3, mk_req(32'h0A0000FE, 16'd443, 6'd9, 1'b0, 4'd3));
    wait_acc(3);
    wait_fwd();
    send_rsp(mk_rsp(4'd3, 6'd8, 10'd1, 1'b1));
    chk("mismatch_drop", 128'(drop_cnt), 128'(1));
    chk("mismatch_no_rsp", 128'(m_open_rsp_vld), 128'(0));
    chk("mismatch_waiting", 128'(s_open_rsp_rdy), 128'(1));
    exp_port_q.push_back(3);
    exp_rsp_q.push_back(mk_rsp(4'd3, 6'd9, 10'd33, 1'b1));
    send_rsp(mk_rsp(4'd3, 6'd9, 10'd33, 1'b1));
    repeat (2) tick();

    // Response arriving while idle is stale
    send_rsp(mk_rsp(4'd1, 6'd1, 10'd2, 1'b1));
    tick();
    chk("idle_drop", 128'(drop_cnt), 128'(2));

`ifdef TCP_OPEN_TIMEOUT_EN
    exp_req_q.push_back(mk_req(32'h0A000010, 16'd22, 6'd30, 1'b0, 4'd2));
    set_req(2, mk_req(32'h0A000010, 16'd22, 6'd30, 1'b0, 4'd2));
    wait_acc(2);
    wait_fwd();
    repeat (90) tick();
    chk("tmo_early", 128'(m_open_rsp_vld), 128'(0));
    exp_port_q.push_back(2);
    exp_rsp_q.push_back(mk_rsp(4'd2, 6'd30, 10'd0, 1'b0));
    for (int i = 0; i < 30 && exp_rsp_q.size() != 0; i++) tick();
    chk("tmo_delivered", 128'(exp_rsp_q.size()), 128'(0));
    send_rsp(mk_rsp(4'd2, 6'd30, 10'd5, 1'b1));
    tick();
    chk("tmo_late_drop", 128'(drop_cnt), 128'(3));
`endif

    // Downstream stalled for 50 cycles, then reset mid-flight
    exp_req_q.push_back(mk_req(32'h0A000020, 16'd9000, 6'd40, 1'b0, 4'd0));
    m_open_req_rdy = 1'b0;
    set_req(0, mk_req(32'h0A000020, 16'd9000, 6'd40, 1'b0, 4'd0));
    wait_acc(0);
    repeat (50) tick();
    chk("stall_vld", 128'(m_open_req_vld), 128'(1));
    chk("stall_dat", 128'(m_open_req_dat), 128'(mk_req(32'h0A000020, 16'd9000, 6'd40, 1'b0, 4'd0)));
    areset = 1'b1;
    tick();
    chk("rst2_m_req_vld", 128'(m_open_req_vld), 128'(0));
    chk("rst2_drop", 128'(drop_cnt), 128'(0));
    chk("rst2_m_rsp_vld", 128'(m_open_rsp_vld), 128'(0));
    areset = 1'b0;
    m_open_req_rdy = 1'b1;
    exp_req_q.delete();
    // rr_ptr back at 0: port 0 wins over port 1
    exp_req_q.push_back(mk_req(32'h0A000030, 16'd1, 6'd2, 1'b1, 4'd0));
    exp_req_q.push_back(mk_req(32'h0A000031, 16'd2, 6'd3, 1'b1, 4'd1));
    set_req(0, mk_req(32'h0A000030, 16'd1, 6'd2, 1'b1, 4'd7));
    set_req(1, mk_req(32'h0A000031, 16'd2, 6'd3, 1'b1, 4'd7));
    wait_fwd();
    wait_fwd();
    repeat (3) tick();

    chk("req_queue_empty", 128'(exp_req_q.size()), 128'(0));
    chk("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tcp_open_arbiter.md
# tcp_open_arbiter

Sits directly upstream of the TCP connection table. Collects open/close requests from N_REGIONS vFPGA ports, round-robins them into one serialized request stream with at most one open in flight, and returns each open response to the vFPGA that issued it. Overwrites the request `vfid` with the physical port index so a vFPGA cannot open or close on behalf of another region.

## Interface
- N_REGIONS, default N_REGIONS (lynxTypes): number of vFPGA request ports, 1..16.
- OPEN_TIMEOUT, default 2**20: cycles to wait for an open response (only with TCP_OPEN_TIMEOUT_EN).
- aclk  in  1  clock; single clock domain.
- areset  in  1  synchronous, active-high reset.
- s_open_req[N_REGIONS]  metaIntf.s  tcp_open_req_r_t  per-vFPGA requests: ip_address, ip_port, pid, dest, route_id[13:0], close, vfid (ignored).
- m_open_req  metaIntf.m  tcp_open_req_r_t  serialized request to the connection table; vfid = granted index.
- s_open_rsp  metaIntf.s  tcp_open_rsp_r_t  response from the connection table: vfid, pid, sid, success.
- m_open_rsp[N_REGIONS]  metaIntf.m  tcp_open_rsp_r_t  per-vFPGA responses.
- drop_cnt  out  16  stale or unmatched responses discarded; saturating.

## Operation
- States: ST_IDLE, ST_FWD, ST_WAIT_RSP, ST_RSP.
- ST_IDLE:
  - Grant the first valid port at or after `rr_ptr_C`, searching modulo N_REGIONS.
  - Assert that port's ready for one cycle.
  - Capture the payload and force vfid = index.
  - Set rr_ptr_N = index+1. Wrap N_REGIONS-1 → 0.
  - Go to ST_FWD.
- ST_FWD: m_open_req.valid=1 with the captured payload until ready. Then go to ST_IDLE if `close`; otherwise reset the timeout counter and go to ST_WAIT_RSP. Close requests get no response.
- ST_WAIT_RSP:
  - s_open_rsp.ready=1.
  - If {vfid,pid} equals the captured {vfid,pid}: latch the response and go to ST_RSP.
  - On mismatch: discard the response, increment drop_cnt, stay.
- ST_RSP: m_open_rsp[vfid_C].valid=1 with the latched response until that port's ready, then go to ST_IDLE. All other m_open_rsp ports hold valid=0.
- In ST_IDLE and ST_FWD, s_open_rsp.ready=1 and every arriving response is discarded and counted (stale after timeout).
- Only one request is outstanding. No new grant until the response has been delivered or the timeout has fired.
- A late response whose vfid/pid matches a newer identical request is accepted for that newer request. This is a documented limitation.

## Timing
- Reset: state ST_IDLE, rr_ptr 0, all valid/ready outputs 0, drop_cnt 0, timeout counter 0, captured payload 0.
- Request accepted in cycle t → m_open_req.valid at t+1. Back-to-back closes sustain one request per 2 cycles when downstream ready=1.
- s_open_rsp handshake in cycle t → m_open_rsp[vfid].valid at t+1.
- All valid outputs are registered. Payload is stable while valid && !ready.
- Simultaneous requests on all ports: grant order is rr_ptr, rr_ptr+1, … with no port served twice before the others.
- Reset in any state returns to the reset values the next cycle; the in-flight request is lost.
- drop_cnt saturates at 16'hFFFF.

## Configuration
- TCP_OPEN_TIMEOUT_EN defined:
  - ST_WAIT_RSP counts cycles.
  - After OPEN_TIMEOUT cycles without a match, latch a synthetic response: vfid_C, pid_C, sid=0, success=0. Go to ST_RSP.
  - A later real response is discarded by the idle/fwd drop rule.
- Undefined: no counter; ST_WAIT_RSP waits indefinitely.

## Structure
- tcp_open_req_r_t and tcp_open_rsp_r_t are the existing lynxTypes definitions.
- Add TCP_OPEN_TIMEOUT_DEF to lynxTypes.
- One sub-module: `rr_arbiter_n`. It takes a request vector and rr_ptr, returns a one-hot grant plus index, and is purely combinational. rr_ptr stays in the parent.

## Test plan
- Single open on port 2 (ip 0x0A000001, port 5001); response sid=7, success=1 → m_open_req.vfid=2; m_open_rsp[2] gets sid 7, success 1; other ports are silent.
- Ports 0, 1, 3 request simultaneously with rr_ptr=1 → grant order 1, 3, 0; each gets exactly one response.
- Close on port 1 (close=1, vfid field=5) → m_open_req.vfid=1, close=1; no m_open_rsp; back in ST_IDLE after ready.
- Response with mismatched pid while waiting → dropped, drop_cnt=1, still waiting; the matching response is then delivered.
- Timeout (TCP_OPEN_TIMEOUT_EN, OPEN_TIMEOUT=100): no response for 100 cycles → success=0 delivered to requester; a late response is discarded and drop_cnt increments.
- m_open_req.ready held low 50 cycles, then areset pulse → all valids 0, rr_ptr 0, and a new request is granted normally.
